iter_alu: RTL and testbench

ITER_ALU -- requirements
Module: iter_alu

---
 rtl/iter_alu.sv | 222 ++++++++++++++++++++++
 tb/tb_iter_alu.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_alu.sv
// Multi-cycle ALU: add/sub/logic/compare finish in one step, multiply and
// divide iterate one bit per cycle (shift-add and restoring division).
module iter_alu #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             en_unsigned,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] remainder,
  output logic             zero,
  output logic             overflow,
  output logic             underflow,
  output logic             div_by_zero,
  output logic [1:0]       comp
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic             r_is_div, r_uns, r_neg, r_rem_neg, r_min_neg1;
  logic [WIDTH-1:0] r_mcand, r_acc, r_sh;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done, r_zero, r_ovf, r_unf, r_dbz;
  logic [WIDTH-1:0] r_result, r_result_hi, r_remainder;
  logic [1:0]       r_comp;

  logic             w_is_mul, w_is_div, w_iter, w_sign_a, w_sign_b, w_min_neg1;
  logic [WIDTH-1:0] w_mag_a, w_mag_b;
  logic [WIDTH:0]   w_add, w_sub;
  logic [WIDTH-1:0] w_res, w_rem;
  logic             w_ovf, w_unf, w_dbz;
  logic [1:0]       w_comp;

  assign w_is_mul   = (op[3:1] == 3'b101);
  assign w_is_div   = (op[3:1] == 3'b110);
  assign w_iter     = w_is_mul | (w_is_div & (b != '0));
  assign w_sign_a   = ~en_unsigned & a[WIDTH-1];
  assign w_sign_b   = ~en_unsigned & b[WIDTH-1];
  assign w_mag_a    = w_sign_a ? -a : a;
  assign w_mag_b    = w_sign_b ? -b : b;
  assign w_min_neg1 = ~en_unsigned & (a == {1'b1, {(WIDTH-1){1'b0}}}) & (b == '1);
  assign w_add      = {1'b0, a} + {1'b0, b};
  assign w_sub      = {1'b0, a} - {1'b0, b};

  always_comb begin
    w_comp = 2'b00;
    if (a == b)
      w_comp = 2'b01;
    else if (en_unsigned ? (a > b) : ($signed(a) > $signed(b)))
      w_comp = 2'b10;
  end

  // Single-step results; the divide entry only matters for b == 0.
  always_comb begin
    w_res = '0;
    w_rem = '0;
    w_ovf = 1'b0;
    w_unf = 1'b0;
    w_dbz = 1'b0;
    case (op)
      4'b0000, 4'b0001: begin
        w_res = w_add[WIDTH-1:0];
        if (en_unsigned) begin
          w_ovf = w_add[WIDTH];
        end else begin
          w_ovf = ~a[WIDTH-1] & ~b[WIDTH-1] &  w_add[WIDTH-1];
          w_unf =  a[WIDTH-1] &  b[WIDTH-1] & ~w_add[WIDTH-1];
        end
      end
      4'b0010, 4'b0011: begin
        w_res = w_sub[WIDTH-1:0];
        if (en_unsigned) begin
          w_unf = w_sub[WIDTH];
        end else begin
          w_ovf = ~a[WIDTH-1] &  b[WIDTH-1] &  w_sub[WIDTH-1];
          w_unf =  a[WIDTH-1] & ~b[WIDTH-1] & ~w_sub[WIDTH-1];
        end
      end
      4'b0100: w_res = a & b;
      4'b0101: w_res = a | b;
      4'b0110: w_res = ~(a & b);
      4'b0111: w_res = ~(a | b);
      4'b1000: w_res = a ^ b;
      4'b1001: w_res = ~(a ^ b);
      4'b1100, 4'b1101: begin
        w_res = '1;
        w_rem = a;
        w_dbz = 1'b1;
      end
      4'b1110: w_res = ~a;
      default: ;
    endcase
  end

  // One iteration step: r_acc holds product-high / partial remainder,
  // r_sh holds multiplier bits / dividend-then-quotient bits.
  logic [WIDTH:0]     w_mul_sum, w_div_shift;
  logic [WIDTH-1:0]   w_mul_acc, w_mul_sh, w_div_acc, w_div_sh, w_quot, w_rmd;
  logic               w_div_ok, w_mul_ovf;
  logic [2*WIDTH-1:0] w_prod, w_prod_s;

  assign w_mul_sum   = {1'b0, r_acc} + (r_sh[0] ? {1'b0, r_mcand} : '0);
  assign w_mul_acc   = w_mul_sum[WIDTH:1];
  assign w_mul_sh    = {w_mul_sum[0], r_sh[WIDTH-1:1]};
  assign w_div_shift = {r_acc, r_sh[WIDTH-1]};
  assign w_div_ok    = (w_div_shift >= {1'b0, r_mcand});
  assign w_div_acc   = w_div_ok ? (w_div_shift[WIDTH-1:0] - r_mcand) : w_div_shift[WIDTH-1:0];
  assign w_div_sh    = {r_sh[WIDTH-2:0], w_div_ok};

  assign w_prod    = {w_mul_acc, w_mul_sh};
  assign w_prod_s  = r_neg ? -w_prod : w_prod;
  assign w_mul_ovf = r_uns ? (w_prod_s[2*WIDTH-1:WIDTH] != '0)
                           : (w_prod_s[2*WIDTH-1:WIDTH] != {WIDTH{w_prod_s[WIDTH-1]}});
  assign w_quot    = r_neg ? -w_div_sh : w_div_sh;
  assign w_rmd     = r_rem_neg ? -w_div_acc : w_div_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_is_div    <= 1'b0;
      r_uns       <= 1'b0;
      r_neg       <= 1'b0;
      r_rem_neg   <= 1'b0;
      r_min_neg1  <= 1'b0;
      r_mcand     <= '0;
      r_acc       <= '0;
      r_sh        <= '0;
      r_cnt       <= '0;
      r_done      <= 1'b0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_remainder <= '0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_dbz       <= 1'b0;
      r_comp      <= 2'b00;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_is_div   <= w_is_div;
            r_uns      <= en_unsigned;
            r_neg      <= w_sign_a ^ w_sign_b;
            r_rem_neg  <= w_sign_a;
            r_min_neg1 <= w_min_neg1;
            if (w_iter) begin
              r_state <= S_RUN;
              r_mcand <= w_mag_b;
              r_acc   <= '0;
              r_sh    <= w_mag_a;
              r_cnt   <= '0;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              if (op == 4'b1111) begin
                r_comp <= w_comp;
              end else begin
                r_result    <= w_res;
                r_result_hi <= '0;
                r_remainder <= w_rem;
                r_zero      <= (w_res == '0);
                r_ovf       <= w_ovf;
                r_unf       <= w_unf;
                r_dbz       <= w_dbz;
              end
            end
          end
        end
        S_RUN: begin
          r_acc <= r_is_div ? w_div_acc : w_mul_acc;
          r_sh  <= r_is_div ? w_div_sh  : w_mul_sh;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_STEP) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_unf   <= 1'b0;
            r_dbz   <= 1'b0;
            if (r_is_div) begin
              r_result    <= w_quot;
              r_result_hi <= '0;
              r_remainder <= w_rmd;
              r_zero      <= (w_quot == '0);
              r_ovf       <= r_min_neg1;
            end else begin
              r_result    <= w_prod_s[WIDTH-1:0];
              r_result_hi <= w_prod_s[2*WIDTH-1:WIDTH];
              r_remainder <= '0;
              r_zero      <= (w_prod_s[WIDTH-1:0] == '0);
              r_ovf       <= w_mul_ovf;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign result      = r_result;
  assign result_hi   = r_result_hi;
  assign remainder   = r_remainder;
  assign zero        = r_zero;
  assign overflow    = r_ovf;
  assign underflow   = r_unf;
  assign div_by_zero = r_dbz;
  assign comp        = r_comp;

endmodule

// File: tb/tb_iter_alu.sv
// Scoreboard bench for iter_alu (WIDTH=8): expected results come from an
// integer reference model and are compared when done pulses.
module tb_iter_alu;
  localparam int W = 8;

  logic         clk, rst_n, start, en_unsigned;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, zero, overflow, underflow, div_by_zero;
  logic [W-1:0] result, result_hi, remainder;
  logic [1:0]   comp;

  iter_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .en_unsigned(en_unsigned), .busy(busy), .done(done), .result(result),
    .result_hi(result_hi), .remainder(remainder), .zero(zero),
    .overflow(overflow), .underflow(underflow), .div_by_zero(div_by_zero),
    .comp(comp)
  );

  typedef struct packed {
    logic [15:0] id;
    logic [7:0]  res;
    logic [7:0]  hi;
    logic [7:0]  rem;
    logic        zero, ovf, unf, dbz;
    logic [1:0]  comp;
    logic [4:0]  lat;
  } exp_t;

  exp_t sb_q[$];
  exp_t m;
  exp_t mon_e;
  int n_checks = 0, n_errors = 0, n_ops = 0;
  int done_cnt = 0, busy_run = 0, cyc = 0, acc_cyc = 0, snap = 0;
  logic [3:0] rnd_op;
  logic [7:0] rnd_a, rnd_b;
  logic       rnd_u;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                                 input logic u, input exp_t prev);
    exp_t e;
    longint va, vb, r, q;
    e = prev;
    e.lat = 5'd1;
    va = u ? longint'(x) : longint'($signed(x));
    vb = u ? longint'(y) : longint'($signed(y));
    if (o == 4'hF) begin
      e.comp = (va > vb) ? 2'b10 : ((va == vb) ? 2'b01 : 2'b00);
      return e;
    end
    e.hi = 8'h00; e.rem = 8'h00; e.ovf = 1'b0; e.unf = 1'b0; e.dbz = 1'b0;
    case (o[3:1])
      3'b000: begin
        r = va + vb; e.res = r[7:0];
        if (u) e.ovf = (r > 255);
        else begin e.ovf = (r > 127); e.unf = (r < -128); end
      end
      3'b001: begin
        r = va - vb; e.res = r[7:0];
        if (u) e.unf = (r < 0);
        else begin e.ovf = (r > 127); e.unf = (r < -128); end
      end
      3'b010: e.res = o[0] ? (x | y) : (x & y);
      3'b011: e.res = o[0] ? ~(x | y) : ~(x & y);
      3'b100: e.res = o[0] ? ~(x ^ y) : (x ^ y);
      3'b101: begin
        r = va * vb;
        e.res = r[7:0]; e.hi = r[15:8];
        e.ovf = u ? (r > 255) : ((r > 127) || (r < -128));
        e.lat = 5'd9;
      end
      3'b110: begin
        if (vb == 0) begin
          e.res = 8'hFF; e.rem = x; e.dbz = 1'b1;
        end else begin
          q = va / vb; r = va % vb;
          e.res = q[7:0]; e.rem = r[7:0];
          e.ovf = !u && (q > 127);
          e.lat = 5'd9;
        end
      end
      default: e.res = ~x;
    endcase
    e.zero = (e.res == 8'h00);
    return e;
  endfunction

  // Output monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_run = busy_run + 1;
      if (done) begin
        done_cnt++;
        if (sb_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check($sformatf("op%0d result", mon_e.id), 64'(result), 64'(mon_e.res));
          check($sformatf("op%0d result_hi", mon_e.id), 64'(result_hi), 64'(mon_e.hi));
          check($sformatf("op%0d remainder", mon_e.id), 64'(remainder), 64'(mon_e.rem));
          check($sformatf("op%0d flags_z_o_u_d", mon_e.id),
                64'({zero, overflow, underflow, div_by_zero}),
                64'({mon_e.zero, mon_e.ovf, mon_e.unf, mon_e.dbz}));
          check($sformatf("op%0d comp", mon_e.id), 64'(comp), 64'(mon_e.comp));
          check($sformatf("op%0d latency", mon_e.id), 64'(cyc - acc_cyc), 64'(mon_e.lat));
          check($sformatf("op%0d busy_cycles", mon_e.id), 64'(busy_run), 64'(mon_e.lat));
          $display("op%0d done: result=%02h hi=%02h rem=%02h z=%b o=%b u=%b d=%b comp=%b",
                   mon_e.id, result, result_hi, remainder, zero, overflow, underflow,
                   div_by_zero, comp);
        end
      end
      if (!busy) busy_run = 0;
    end else begin
      busy_run = 0;
    end
  end

  task automatic issue_op(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                          input logic u);
    exp_t e;
    @(negedge clk);
    op = o; a = x; b = y; en_unsigned = u; start = 1'b1;
    e = model(o, x, y, u, m);
    e.id = 16'(n_ops);
    n_ops++;
    m = e;
    sb_q.push_back(e);
    @(posedge clk);
    acc_cyc = cyc;
    #1;
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); op = 4'($urandom); en_unsigned = 1'($urandom);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (sb_q.size() != 0) begin
      check("done_timeout", 64'(sb_q.size()), 64'd0);
      sb_q.delete();
    end
  endtask

  task automatic do_op(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                       input logic u);
    issue_op(o, x, y, u);
    wait_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1; start = 1'b0; op = 4'h0; a = '0; b = '0; en_unsigned = 1'b0;
    m = '0;
    #2 rst_n = 1'b0;
    #2;
    check("reset_outputs",
          64'({busy, done, result, result_hi, remainder, zero, overflow, underflow, div_by_zero, comp}),
          64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_op(4'h0, 8'h7F, 8'h01, 1'b0);   // signed add overflow
    do_op(4'hA, 8'hF0, 8'h10, 1'b1);   // unsigned mul 0x0F00
    do_op(4'hC, 8'hF9, 8'h02, 1'b0);   // -7 / 2
    do_op(4'hD, 8'h55, 8'h00, 1'b0);   // divide by zero
    do_op(4'hF, 8'h80, 8'h01, 1'b0);   // signed compare
    do_op(4'hF, 8'h80, 8'h01, 1'b1);   // unsigned compare
    do_op(4'hC, 8'h80, 8'hFF, 1'b0);   // MIN / -1
    do_op(4'h2, 8'h00, 8'h01, 1'b1);   // unsigned borrow
    do_op(4'h3, 8'h80, 8'h01, 1'b0);   // signed negative overflow
    do_op(4'hB, 8'h80, 8'h80, 1'b0);   // signed MIN*MIN
    do_op(4'hA, 8'hFF, 8'h03, 1'b0);   // -1*3
    do_op(4'h6, 8'hFF, 8'hFF, 1'b1);   // nand -> zero
    do_op(4'hE, 8'h0F, 8'h00, 1'b0);   // not
    do_op(4'hC, 8'h07, 8'hFE, 1'b0);   // 7 / -2

    // start pulsed during a multiply must be ignored
    snap = done_cnt;
    issue_op(4'hA, 8'h12, 8'h34, 1'b1);
    repeat (2) @(negedge clk);
    start = 1'b1; op = 4'h0;
    @(negedge clk);
    check("busy_in_run", 64'(busy), 64'd1);
    start = 1'b0;
    wait_idle();
    repeat (12) @(negedge clk);
    check("single_done", 64'(done_cnt - snap), 64'd1);

    // reset in RUN cycle 4 aborts the multiply
    @(negedge clk);
    op = 4'hA; a = 8'h33; b = 8'h44; en_unsigned = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("busy_before_abort", 64'(busy), 64'd1);
    snap = done_cnt;
    rst_n = 1'b0;
    #1;
    check("abort_outputs",
          64'({busy, done, result, result_hi, remainder, zero, overflow, underflow, div_by_zero, comp}),
          64'd0);
    repeat (3) @(negedge clk);
    m = '0;
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_no_done", 64'(done_cnt - snap), 64'd0);
    do_op(4'h1, 8'h10, 8'h20, 1'b1);   // accepted normally after reset

    for (int i = 0; i < 40; i++) begin
      rnd_op = 4'($urandom_range(0, 15));
      rnd_a  = 8'($urandom);
      rnd_b  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      rnd_u  = 1'($urandom_range(0, 1));
      do_op(rnd_op, rnd_a, rnd_b, rnd_u);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
